// File: rtl/rcc_pkg.sv
// rcc_pkg: shared definitions for the ripple-counter capture stage.
// Holds the counter width, the sampler FSM state type and the modulo-16 delta helper.
package rcc_pkg;

  localparam int RCC_W = 4;

  typedef enum logic {
    INIT  = 1'b0,
    TRACK = 1'b1
  } rcc_smp_state_t;

  // Forward distance from prev to cur on a free-running modulo-2^RCC_W counter.
  function automatic logic [RCC_W-1:0] rcc_delta(input logic [RCC_W-1:0] cur,
                                                 input logic [RCC_W-1:0] prev);
    return cur - prev;
  endfunction

endpackage

// File: rtl/rcc_sync2.sv
// rcc_sync2: per-bit two-flop synchroniser with asynchronous active-high reset.
// Bits are synchronised independently, so a multi-bit bus may be skewed by one
// cycle between bits; the downstream stability filter removes such values.
module rcc_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      // Two back-to-back flops per bit to let metastability resolve.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_s1[gi] <= 1'b0;
          r_s2[gi] <= 1'b0;
        end else begin
          r_s1[gi] <= i_d[gi];
          r_s2[gi] <= r_s1[gi];
        end
      end
    end
  endgenerate

  assign o_q = r_s2;

endmodule

// File: rtl/rcc_sampler.sv
// rcc_sampler: captures the asynchronous 4-bit ripple count, filters ripple
// glitches, accumulates modulo-16 deltas into an ACC_W-bit total and reports
// accumulator snapshots over a valid/ready channel.
// Optional feature: define RCC_SAMPLER_WRAP_EN to build the 15->0 wrap detector
// driving wrap_pulse; otherwise wrap_pulse is tied low.
module rcc_sampler
  import rcc_pkg::*;
#(
  parameter int ACC_W    = 16,
  parameter int STABLE_N = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RCC_W-1:0] rc_q,
  input  logic             clr,
  output logic [ACC_W-1:0] acc,
  output logic             ovf,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [ACC_W-1:0] rpt_acc,
  output logic             wrap_pulse
);

  localparam int               CNT_W    = $clog2(STABLE_N + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STABLE_N);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [RCC_W-1:0] w_s2;

  // Synchroniser fill tracking: s2 only carries real samples from the third edge on.
  logic [1:0]       r_prime;
  logic             w_primed;

  // Stability filter state.
  logic [RCC_W-1:0] r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_accept;

  // Tracking state and accumulator.
  rcc_smp_state_t   r_state;
  rcc_smp_state_t   w_state_next;
  logic [RCC_W-1:0] r_last;
  logic [RCC_W-1:0] w_last_next;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_next;
  logic             r_ovf;
  logic             w_ovf_next;
  logic [ACC_W-1:0] w_delta;
  logic [ACC_W:0]   w_sum;
  logic             w_step;

  // Report channel.
  logic             r_rpt_valid;
  logic             w_rpt_valid_next;
  logic [ACC_W-1:0] r_rpt_acc;
  logic [ACC_W-1:0] w_rpt_acc_next;
  logic             r_upd;
  logic             w_upd_next;
  logic             w_launch;

  rcc_sync2 #(
    .W(RCC_W)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .i_d  (rc_q),
    .o_q  (w_s2)
  );

  assign w_primed = (r_prime == 2'd2);

  // Count up to two edges after reset so the reset zeros in the synchroniser are never filtered as data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prime <= 2'd0;
    end else if (!w_primed) begin
      r_prime <= r_prime + 2'd1;
    end
  end

  // Filter: count consecutive identical samples; accept on the edge that reaches STABLE_N.
  always_comb begin
    w_cnt_next = r_cnt;
    w_accept   = 1'b0;
    if (w_primed) begin
      if (w_s2 != r_cand) begin
        w_cnt_next = CNT_ONE;
      end else if (r_cnt != CNT_FULL) begin
        w_cnt_next = r_cnt + CNT_ONE;
      end
      w_accept = (w_cnt_next == CNT_FULL) && ((r_cnt != CNT_FULL) || (w_s2 != r_cand));
    end
  end

  // Filter registers, only advanced once the synchroniser holds real samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cand <= '0;
      r_cnt  <= '0;
    end else if (w_primed) begin
      r_cand <= w_s2;
      r_cnt  <= w_cnt_next;
    end
  end

  assign w_delta = ACC_W'(rcc_delta(w_s2, r_last));
  assign w_sum   = {1'b0, r_acc} + {1'b0, w_delta};
  assign w_step  = w_accept && (r_state == TRACK) && (w_s2 != r_last);

  // Next-state and datapath: INIT loads the first accepted value, TRACK accumulates deltas; clr zeroes acc/ovf but keeps counts from a coincident accept.
  always_comb begin
    w_state_next = r_state;
    w_last_next  = r_last;
    w_acc_next   = r_acc;
    w_ovf_next   = r_ovf;
    if (clr) begin
      w_acc_next = '0;
      w_ovf_next = 1'b0;
    end
    case (r_state)
      INIT: begin
        if (w_accept) begin
          w_last_next  = w_s2;
          w_state_next = TRACK;
        end
      end
      TRACK: begin
        if (w_step) begin
          w_last_next = w_s2;
          if (clr) begin
            w_acc_next = w_delta;
          end else begin
            w_acc_next = w_sum[ACC_W-1:0];
            w_ovf_next = r_ovf | w_sum[ACC_W];
          end
        end
      end
      default: w_state_next = INIT;
    endcase
  end

  // FSM and accumulator registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= INIT;
      r_last  <= '0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_last  <= w_last_next;
      r_acc   <= w_acc_next;
      r_ovf   <= w_ovf_next;
    end
  end

  // Report: launch the current acc when idle with an unreported update; hold the snapshot until the handshake.
  always_comb begin
    w_launch         = !r_rpt_valid && r_upd;
    w_rpt_valid_next = r_rpt_valid ? !rpt_ready : r_upd;
    w_rpt_acc_next   = w_launch ? r_acc : r_rpt_acc;
    w_upd_next       = w_launch ? w_step : (r_upd | w_step);
  end

  // Report channel registers; reset discards any pending report.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rpt_valid <= 1'b0;
      r_rpt_acc   <= '0;
      r_upd       <= 1'b0;
    end else begin
      r_rpt_valid <= w_rpt_valid_next;
      r_rpt_acc   <= w_rpt_acc_next;
      r_upd       <= w_upd_next;
    end
  end

`ifdef RCC_SAMPLER_WRAP_EN
  logic r_wrap;

  // Pulse for one cycle after an accepted step that went backwards numerically, i.e. the counter wrapped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_step && (w_s2 < r_last);
    end
  end

  assign wrap_pulse = r_wrap;
`else
  assign wrap_pulse = 1'b0;
`endif

  assign acc       = r_acc;
  assign ovf       = r_ovf;
  assign rpt_valid = r_rpt_valid;
  assign rpt_acc   = r_rpt_acc;

endmodule

// File: tb/tb_rcc_sampler.sv
// tb_rcc_sampler: directed test-plan steps followed by randomized rc_q segments,
// checked against a behavioural model of accepted counts, deltas and reports.
module tb_rcc_sampler;

`ifdef RCC_SAMPLER_WRAP_EN
  localparam int WRAP_ON = 1;
`else
  localparam int WRAP_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rc_q;
  logic        clr;
  logic [15:0] acc;
  logic        ovf;
  logic        rpt_valid;
  logic        rpt_ready;
  logic [15:0] rpt_acc;
  logic        wrap_pulse;

  logic [3:0]  rc_q4;
  logic        clr4;
  logic [3:0]  acc4;
  logic        ovf4;
  logic        rpt_valid4;
  logic [3:0]  rpt_acc4;
  logic        wrap_pulse4;

  int tests = 0;
  int fails = 0;
  int wrap_cnt;
  int valid_cnt;
  int last_hs;

  always #5 clk = ~clk;

  rcc_sampler #(.ACC_W(16), .STABLE_N(2)) dut (
    .clk(clk), .reset(reset), .rc_q(rc_q), .clr(clr), .acc(acc), .ovf(ovf),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_acc(rpt_acc), .wrap_pulse(wrap_pulse)
  );

  rcc_sampler #(.ACC_W(4), .STABLE_N(2)) dut4 (
    .clk(clk), .reset(reset), .rc_q(rc_q4), .clr(clr4), .acc(acc4), .ovf(ovf4),
    .rpt_valid(rpt_valid4), .rpt_ready(1'b1), .rpt_acc(rpt_acc4), .wrap_pulse(wrap_pulse4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge; inputs must already be set. Checks the hold rule and records handshakes.
  task automatic tick();
    logic        hold_p;
    logic        hs;
    logic [15:0] snap;
    hold_p = rpt_valid && !rpt_ready;
    hs     = rpt_valid && rpt_ready;
    snap   = rpt_acc;
    @(posedge clk);
    #1;
    if (hold_p) begin
      check("hold_valid", {31'd0, rpt_valid}, 32'd1);
      check("hold_rpt_acc", {16'd0, rpt_acc}, {16'd0, snap});
    end
    if (hs) last_hs = int'(snap);
    wrap_cnt  += int'(wrap_pulse);
    valid_cnt += int'(rpt_valid);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int acc_m, ovf_m, last_m, wrap_exp;
    int acc4_m, ovf4_m, last4_m;
    int d, hold, nv;
    logic [3:0] v;
    logic do_clr;

    reset = 1'b1; rc_q = 4'd5; clr = 1'b0; rpt_ready = 1'b0;
    rc_q4 = 4'd0; clr4 = 1'b0;
    wrap_cnt = 0; valid_cnt = 0; last_hs = -1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_acc", {16'd0, acc}, 0);
    check("rst_ovf", {31'd0, ovf}, 0);
    check("rst_valid", {31'd0, rpt_valid}, 0);
    check("rst_rpt_acc", {16'd0, rpt_acc}, 0);
    check("rst_wrap", {31'd0, wrap_pulse}, 0);
    @(negedge clk);
    reset = 1'b0;

    // rc_q held at 5 through reset: first accept only loads the baseline.
    ticks(4);
    check("init_acc", {16'd0, acc}, 0);
    check("init_valid", {31'd0, rpt_valid}, 0);
    check("init_ovf", {31'd0, ovf}, 0);
    acc_m = 0; ovf_m = 0; last_m = 5;

    // 5 -> 9: accept three edges after the edge that first samples 9.
    rpt_ready = 1'b1; rc_q = 4'd9;
    ticks(3);
    check("step9_before", {16'd0, acc}, 0);
    tick();
    acc_m = 4; last_m = 9;
    check("step9_acc", {16'd0, acc}, acc_m);
    check("step9_valid_lat", {31'd0, rpt_valid}, 0);
    tick();
    check("step9_valid", {31'd0, rpt_valid}, 1);
    check("step9_rpt_acc", {16'd0, rpt_acc}, 4);
    tick();
    check("step9_retire", {31'd0, rpt_valid}, 0);

    // 9 -> 14, then 14 -> 2 across the wrap.
    rc_q = 4'd14;
    ticks(6);
    acc_m = 9; last_m = 14;
    check("step14_acc", {16'd0, acc}, acc_m);
    wrap_cnt = 0;
    rc_q = 4'd2;
    ticks(8);
    acc_m = 13; last_m = 2;
    check("wrap_acc", {16'd0, acc}, acc_m);
    check("wrap_pulses", wrap_cnt, WRAP_ON);
    check("wrap_last_hs", last_hs, acc_m);

    // Back-pressure while stepping 2 -> 3 -> 4.
    rpt_ready = 1'b0; rc_q = 4'd3;
    ticks(4);
    rc_q = 4'd4;
    ticks(6);
    acc_m = 15; last_m = 4;
    check("bp_valid", {31'd0, rpt_valid}, 1);
    check("bp_rpt_acc", {16'd0, rpt_acc}, 14);
    check("bp_acc", {16'd0, acc}, acc_m);
    rpt_ready = 1'b1;
    tick();
    check("bp_retire", {31'd0, rpt_valid}, 0);
    tick();
    check("bp_next_valid", {31'd0, rpt_valid}, 1);
    check("bp_next_rpt_acc", {16'd0, rpt_acc}, acc_m);
    ticks(2);

    // One-cycle glitch to 11 then back to 4.
    valid_cnt = 0;
    rc_q = 4'd11;
    tick();
    rc_q = 4'd4;
    ticks(8);
    check("glitch_acc", {16'd0, acc}, acc_m);
    check("glitch_no_report", valid_cnt, 0);

    // ACC_W=4 instance: overflow and clr coincident with an accept.
    rc_q4 = 4'd14;
    ticks(6);
    check("w4_acc14", {28'd0, acc4}, 14);
    check("w4_ovf0", {31'd0, ovf4}, 0);
    rc_q4 = 4'd1;
    ticks(6);
    check("w4_wrap_acc", {28'd0, acc4}, 1);
    check("w4_ovf1", {31'd0, ovf4}, 1);
    rc_q4 = 4'd3;
    ticks(3);
    check("w4_pre_clr_acc", {28'd0, acc4}, 1);
    clr4 = 1'b1;
    tick();
    clr4 = 1'b0;
    check("w4_clr_acc", {28'd0, acc4}, 2);
    check("w4_clr_ovf", {31'd0, ovf4}, 0);
    ticks(2);
    acc4_m = 2; ovf4_m = 0; last4_m = 3;

    // Randomized segments: hold 1 is a rejected glitch, 4..6 is an accepted value.
    wrap_cnt = 0; wrap_exp = 0;
    for (int s = 0; s < 40; s++) begin
      v      = 4'($urandom_range(0, 15));
      hold   = ($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(4, 6));
      do_clr = (hold > 1) && ($urandom_range(0, 4) == 0);
      rc_q   = v;
      rc_q4  = v;
      if (hold > 1) begin
        if (int'(v) != last_m) begin
          if (int'(v) < last_m) wrap_exp++;
          d = (int'(v) - last_m) & 15;
          if (acc_m + d > 65535) ovf_m = 1;
          acc_m  = (acc_m + d) % 65536;
          last_m = int'(v);
        end
        if (do_clr) begin acc4_m = 0; ovf4_m = 0; end
        if (int'(v) != last4_m) begin
          d = (int'(v) - last4_m) & 15;
          if (acc4_m + d > 15) ovf4_m = 1;
          acc4_m  = (acc4_m + d) % 16;
          last4_m = int'(v);
        end
      end
      for (int t = 0; t < hold; t++) begin
        rpt_ready = ($urandom_range(0, 2) != 0);
        clr4      = do_clr && (t == 0);
        tick();
      end
      clr4 = 1'b0;
      if (hold > 1) begin
        check("rnd_acc", {16'd0, acc}, acc_m);
        check("rnd_ovf", {31'd0, ovf}, ovf_m);
        check("rnd_acc4", {28'd0, acc4}, acc4_m);
        check("rnd_ovf4", {31'd0, ovf4}, ovf4_m);
      end
    end
    rpt_ready = 1'b1;
    ticks(8);
    check("rnd_drain_valid", {31'd0, rpt_valid}, 0);
    check("rnd_last_report", last_hs, acc_m);
    check("rnd_wraps", wrap_cnt, wrap_exp * WRAP_ON);

    // Pending report, then asynchronous reset mid-cycle discards it.
    rpt_ready = 1'b0;
    nv = (last_m + 3) & 15;
    rc_q = 4'(nv);
    acc_m = (acc_m + 3) % 65536;
    ticks(6);
    check("pend_valid", {31'd0, rpt_valid}, 1);
    check("pend_rpt_acc", {16'd0, rpt_acc}, acc_m);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, rpt_valid}, 0);
    check("async_rst_acc", {16'd0, acc}, 0);
    check("async_rst_rpt_acc", {16'd0, rpt_acc}, 0);
    check("async_rst_acc4", {28'd0, acc4}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rcc_sampler.md
# rcc_sampler

Clock-domain capture stage for the 4-bit ripple-carry counter output. It synchronises the asynchronous, ripple-skewed count into the system clock domain and rejects intermediate ripple values with a stability filter. Each accepted change is converted into a modulo-16 delta and added to a wide accumulator. Accumulator snapshots are reported to downstream logic over a valid/ready channel.

## Interface
- ACC_W, 16, accumulator width in bits; must be at least 4.
- STABLE_N, 2, number of consecutive identical synchronised samples required to accept a value; must be at least 1.

- clk  input  1  system clock; the block uses rising edges only.
- reset  input  1  reset, asynchronous, active-high.
- rc_q  input  4  ripple counter output; asynchronous to clk; counts up modulo 16.
- clr  input  1  synchronous clear of acc and ovf.
- acc  output  ACC_W  running total of accepted counts.
- ovf  output  1  sticky flag; set on accumulator carry-out.
- rpt_valid  output  1  report available.
- rpt_ready  input  1  consumer accepts the report.
- rpt_acc  output  ACC_W  accumulator snapshot carried by the report.
- wrap_pulse  output  1  one-cycle pulse when the ripple counter wraps from 15 to 0.

## Operation
- Reset values: all outputs 0; synchroniser and filter state 0; FSM in INIT.
- Synchroniser: each bit of rc_q passes through 2 flops, giving s2.
- Stability filter:
  - A value is accepted when s2 holds the same value on STABLE_N consecutive clock edges.
  - Any change in s2 restarts the count.
  - A value equal to the last accepted value produces no action.
- FSM, state INIT:
  - The first accepted value loads last.
  - No accumulation and no report.
  - Transition to TRACK.
- FSM, state TRACK, on each accepted value cur different from last:
  - delta = (cur - last) mod 16, zero-extended to ACC_W.
  - acc <= acc + delta, wrapping modulo 2^ACC_W.
  - ovf <= 1 on carry-out.
  - last <= cur.
- Arithmetic assumption: the counter advances fewer than 16 counts between accepts. Faster input aliases, and this is the integrator's responsibility.
- Report channel:
  - When acc is updated and no report is pending, assert rpt_valid with rpt_acc = the new acc.
  - While rpt_valid=1 and rpt_ready=0, rpt_acc is held stable; later updates change acc only.
  - On a handshake (valid and ready on the same edge), the report retires.
  - If acc differs from the retired snapshot, the next report is presented on the following edge.
  - rpt_valid never drops without a handshake.
- clr:
  - acc <= 0, ovf <= 0; last is kept and the FSM stays in TRACK.
  - A pending report is unaffected.
  - clr coincident with an accept: acc <= delta, ovf <= 0, so no counts are lost.
- Reset mid-operation: everything returns to its reset value, the FSM re-enters INIT, and the pending report is discarded.

## Timing
- rc_q stable before edge 1:
  - s2 valid after edge 2.
  - Accept and acc update at edge 2+STABLE_N; with the default STABLE_N, that is edge 4.
- Report latency: rpt_valid and rpt_acc rise at the edge after the acc update (3+STABLE_N) when no report is pending.
- wrap_pulse is high for the single cycle following an accept where cur < last.
- A glitch shorter than STABLE_N cycles in s2 is never accepted.

## Configuration
- Macro: RCC_SAMPLER_WRAP_EN.
- Defined: wrap detection logic is present and drives wrap_pulse as specified above.
- Undefined: the wrap logic is omitted and wrap_pulse is tied to 0.
- The macro has no effect on acc, ovf or the report channel.

## Structure
- Shared package rcc_pkg:
  - RCC_W = 4.
  - FSM state typedef rcc_smp_state_t with states INIT and TRACK.
- Sub-module rcc_sync2: a 2-flop synchroniser with parameterised width and asynchronous active-high reset, instantiated once with width RCC_W.

## Test plan
- Reset, rc_q held at 5: after 4 edges the FSM is in TRACK with acc=0, rpt_valid=0, ovf=0.
- From last=5, rc_q set to 9 with rpt_ready=1: acc=4; rpt_valid high for 1 cycle with rpt_acc=4.
- rc_q from 14 to 2:
  - acc increases by 4.
  - With RCC_SAMPLER_WRAP_EN defined, wrap_pulse is high for exactly 1 cycle.
  - With the macro undefined, wrap_pulse stays 0 throughout.
- rpt_ready=0 while rc_q steps 2→3→4:
  - rpt_acc keeps the first snapshot value while rpt_valid stays high.
  - After the ready handshake, the next report carries the latest acc.
- rc_q glitches to 11 for 1 clock, then returns to 4: no accept, acc unchanged, no report.
- ACC_W=4:
  - With acc=14, a delta of 3 gives acc=1 and ovf=1.
  - clr coincident with a delta of 2 gives acc=2 and ovf=0.
